audio_sched_ctrl: RTL
=====================

Name: audio_sched_ctrl

Overview:
- Sequencing controller in front of the audio codec core's Avalon-ST sample ports.
- Builds one signed 16-bit sample per stereo frame from the beeper and tape-out levels.
- Pushes that sample into the DAC left channel, then the right channel, paced by the core's ready signals.
- Drains the ADC channels and slices the ADC left channel into a 1-bit tape-in level, using hysteresis.

Parameters:
- BEEP_AMP, 16'sd8192, beeper contribution magnitude (signed).
- TAPE_AMP, 16'sd4096, tape-out contribution magnitude (signed).
- THRESH_HI, 16'sd1024, ADC level above which tape_in goes to 1.
- THRESH_LO, -16'sd1024, ADC level below which tape_in goes to 0; THRESH_LO < THRESH_HI required.

Ports:
- clk_clk  in  1  system clock, same clock as the codec core.
- reset_reset  in  1  synchronous, active-high reset.
- beep_i  in  1  beeper speaker level.
- tape_out_i  in  1  tape/MIC output level.
- mute_i  in  1  forces a zero DAC sample.
- tape_in_o  out  1  sliced tape input level.
- frame_cnt_o  out  16  count of completed stereo frames (wraps).
- dac_l_data_o  out  16  to core to_dac_left data.
- dac_l_valid_o  out  1  to core to_dac_left valid.
- dac_l_ready_i  in  1  from core to_dac_left ready.
- dac_r_data_o  out  16  to core to_dac_right data.
- dac_r_valid_o  out  1  to core to_dac_right valid.
- dac_r_ready_i  in  1  from core to_dac_right ready.
- adc_l_data_i  in  16  from core from_adc_left data.
- adc_l_valid_i  in  1  from core from_adc_left valid.
- adc_l_ready_o  out  1  to core from_adc_left ready.
- adc_r_data_i  in  16  from core from_adc_right data.
- adc_r_valid_i  in  1  from core from_adc_right valid.
- adc_r_ready_o  out  1  to core from_adc_right ready.

Behaviour:
- Clocking and reset: one clock, clk_clk; reset_reset is synchronous and active-high.
- Reset values (at any edge with reset_reset=1, including mid-frame):
  - all valids and readies 0;
  - dac_*_data_o 0;
  - tape_in_o 0;
  - frame_cnt_o 0;
  - FSM goes to LOAD.
  - Dropping valid without a handshake is permitted only through reset; the codec core shares the same reset.
- DAC FSM, states LOAD -> PUSH_L -> PUSH_R -> LOAD:
  - LOAD (1 cycle), mix computation:
    - mix = (beep_i ? +BEEP_AMP : -BEEP_AMP) + (tape_out_i ? +TAPE_AMP : -TAPE_AMP) [+ monitor term].
    - The sum is computed 18-bit signed and saturated to [-32768, 32767].
    - mute_i=1 forces mix = 0.
    - The result is latched into both dac_l_data_o and dac_r_data_o.
  - PUSH_L: dac_l_valid_o=1.
    - dac_l_valid_o & dac_l_ready_i -> PUSH_R; dac_l_valid_o drops on the next edge.
  - PUSH_R: dac_r_valid_o=1.
    - dac_r_valid_o & dac_r_ready_i -> LOAD; frame_cnt_o increments (0xFFFF wraps to 0x0000).
  - Data and valid stay stable while ready=0.
  - Inputs are sampled only in LOAD; changes during PUSH_* are ignored until the next frame.
  - Latency: input sampled at the LOAD edge; data and left valid are visible the following cycle.
  - At most one valid is high at a time.
  - Minimum frame period is 3 cycles with ready held at 1.
- ADC path:
  - adc_l_ready_o and adc_r_ready_o are 1 in every non-reset cycle.
  - Right-channel samples are accepted and discarded.
  - On an adc_l handshake with sample s (signed):
    - s > THRESH_HI -> tape_in_o=1 on the next edge;
    - s < THRESH_LO -> tape_in_o=0;
    - otherwise tape_in_o holds.
  - Boundary: s equal to THRESH_HI or THRESH_LO holds.
  - No handshake -> tape_in_o holds.
- ADC and DAC paths are independent; simultaneous handshakes on both are legal in the same cycle.

Optional Feature:
- Macro AUDIO_SCHED_MONITOR_EN.
- Defined:
  - The last accepted ADC left sample is registered (reset 0), arithmetic-shifted right by 2, and added into the LOAD mix before saturation.
  - This provides audible tape monitoring.
  - mute_i still forces 0.
- Undefined:
  - No monitor register exists; the ADC path only drives tape_in_o; the mix is beep plus tape-out only.

Decomposition:
- Package audio_sched_pkg:
  - typedef sample_t (logic signed [15:0]);
  - FSM state enum {LOAD, PUSH_L, PUSH_R};
  - function sat16 (18-bit signed to sample_t).
- Sub-module audio_tape_slicer:
  - hysteresis comparator;
  - inputs: sample, strobe, thresholds;
  - output: registered level.

Test Plan:
- Mix, defaults, ready held 1: beep=1, tape_out=0, mute=0 -> each frame L then R carry 0x1000 (8192-4096); frame_cnt_o +1 per 3 cycles.
- Backpressure: dac_l_ready_i=0 for 5 cycles -> dac_l_valid_o and data held stable; dac_r_valid_o stays 0; right is pushed only after the left handshake.
- Saturation: BEEP_AMP=30000, TAPE_AMP=4096, both inputs 1 -> data 0x7FFF; both inputs 0 -> 0x8000.
- Hysteresis: ADC left sequence 0, 1025, 500, -1024, -1025 -> tape_in_o = 0, 1, 1, 1, 0; right-channel samples are accepted with no effect.
- Reset mid-frame: assert reset_reset during PUSH_R with ready=0 -> next edge all valids 0, frame_cnt_o 0, state LOAD; the first post-reset frame is correct.
- With AUDIO_SCHED_MONITOR_EN: accepted ADC left 0x4000, beep=1, tape_out=1 -> DAC data 12288+4096 = 0x4000; with mute_i=1 -> 0x0000.

Source files
------------

// File: rtl/audio_sched_pkg.sv
// audio_sched_pkg
// Shared types and helpers for the audio sequencing controller:
//   sample_t  - signed 16-bit audio sample
//   state_t   - DAC push sequencer states (LOAD -> PUSH_L -> PUSH_R)
//   sat16     - clamp an 18-bit signed mix into the 16-bit sample range
package audio_sched_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_PUSH_L = 2'd1,
        ST_PUSH_R = 2'd2
    } state_t;

    localparam sample_t SAMPLE_MAX = 16'sh7FFF;
    localparam sample_t SAMPLE_MIN = 16'sh8000;

    function automatic sample_t sat16(input logic signed [17:0] x);
        if (x > 18'sd32767) begin
            return SAMPLE_MAX;
        end else if (x < -18'sd32768) begin
            return SAMPLE_MIN;
        end else begin
            return x[15:0];
        end
    endfunction

endpackage

// File: rtl/audio_tape_slicer.sv
// audio_tape_slicer
// Hysteresis comparator turning a stream of signed ADC samples into a
// 1-bit level. Only strobed samples are considered; the level moves to 1
// strictly above thresh_hi_i, to 0 strictly below thresh_lo_i, and holds
// otherwise (including samples exactly equal to either threshold).
// Ports:
//   clk, srst     - clock and synchronous active-high reset (level -> 0)
//   sample_i      - signed sample
//   strobe_i      - sample_i is a fresh accepted sample this cycle
//   thresh_hi_i   - upper threshold
//   thresh_lo_i   - lower threshold (must be below thresh_hi_i)
//   level_o       - registered sliced level
module audio_tape_slicer
    import audio_sched_pkg::*;
(
    input  logic    clk,
    input  logic    srst,
    input  sample_t sample_i,
    input  logic    strobe_i,
    input  sample_t thresh_hi_i,
    input  sample_t thresh_lo_i,
    output logic    level_o
);

    logic level_q;
    logic level_d;

    always_comb begin
        level_d = level_q;
        if (strobe_i) begin
            if (sample_i > thresh_hi_i) begin
                level_d = 1'b1;
            end else if (sample_i < thresh_lo_i) begin
                level_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/audio_sched_ctrl.sv
// audio_sched_ctrl
// Sequencer in front of the codec core's Avalon-ST sample ports.
// Once per stereo frame it mixes the beeper and tape-out levels into one
// signed sample, then pushes it to the DAC left port and afterwards to the
// DAC right port. The ADC ports are always drained; the left channel feeds
// a hysteresis slicer producing tape_in_o, the right channel is discarded.
// Optional build macro AUDIO_SCHED_MONITOR_EN: when defined, the last
// accepted ADC left sample (>>>2) is added into the mix for tape monitoring.
// Ports:
//   clk_clk, reset_reset          - clock, synchronous active-high reset
//   beep_i, tape_out_i, mute_i    - mix sources, sampled in LOAD only
//   tape_in_o                     - sliced tape input level
//   frame_cnt_o                   - completed stereo frames (wraps)
//   dac_l_* / dac_r_*             - DAC sample streams to the core
//   adc_l_* / adc_r_*             - ADC sample streams from the core
module audio_sched_ctrl
    import audio_sched_pkg::*;
#(
    parameter logic signed [15:0] BEEP_AMP  = 16'sd8192,
    parameter logic signed [15:0] TAPE_AMP  = 16'sd4096,
    parameter logic signed [15:0] THRESH_HI = 16'sd1024,
    parameter logic signed [15:0] THRESH_LO = -16'sd1024
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        beep_i,
    input  logic        tape_out_i,
    input  logic        mute_i,
    output logic        tape_in_o,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] dac_l_data_o,
    output logic        dac_l_valid_o,
    input  logic        dac_l_ready_i,
    output logic [15:0] dac_r_data_o,
    output logic        dac_r_valid_o,
    input  logic        dac_r_ready_i,
    input  logic [15:0] adc_l_data_i,
    input  logic        adc_l_valid_i,
    output logic        adc_l_ready_o,
    input  logic [15:0] adc_r_data_i,
    input  logic        adc_r_valid_i,
    output logic        adc_r_ready_o
);

    localparam logic signed [17:0] BEEP_W = 18'(BEEP_AMP);
    localparam logic signed [17:0] TAPE_W = 18'(TAPE_AMP);

    state_t            state_q, state_d;
    sample_t           dac_data_q, dac_data_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic signed [17:0] mix_wide;
    logic              adc_ready;
    logic              adc_l_fire;

    // ADC side never stalls the core outside reset.
    assign adc_ready     = ~reset_reset;
    assign adc_l_ready_o = adc_ready;
    assign adc_r_ready_o = adc_ready;
    assign adc_l_fire    = adc_l_valid_i & adc_ready;

    // Right-channel ADC samples are accepted and intentionally dropped.
    logic adc_r_unused;
    assign adc_r_unused = ^{adc_r_data_i, adc_r_valid_i};

`ifdef AUDIO_SCHED_MONITOR_EN
    sample_t mon_q, mon_d;

    always_comb begin
        mon_d = mon_q;
        if (adc_l_fire) begin
            mon_d = adc_l_data_i;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            mon_q <= '0;
        end else begin
            mon_q <= mon_d;
        end
    end

    always_comb begin
        mix_wide = (beep_i     ? BEEP_W : -BEEP_W)
                 + (tape_out_i ? TAPE_W : -TAPE_W)
                 + 18'(sample_t'(mon_q >>> 2));
    end
`else
    always_comb begin
        mix_wide = (beep_i     ? BEEP_W : -BEEP_W)
                 + (tape_out_i ? TAPE_W : -TAPE_W);
    end
`endif

    // Push sequencer: valids are decoded from state so at most one is
    // ever high, and data only changes in LOAD, keeping it stable while
    // the core applies backpressure.
    always_comb begin
        state_d     = state_q;
        dac_data_d  = dac_data_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            ST_LOAD: begin
                dac_data_d = mute_i ? '0 : sat16(mix_wide);
                state_d    = ST_PUSH_L;
            end
            ST_PUSH_L: begin
                if (dac_l_ready_i) begin
                    state_d = ST_PUSH_R;
                end
            end
            ST_PUSH_R: begin
                if (dac_r_ready_i) begin
                    state_d     = ST_LOAD;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q     <= ST_LOAD;
            dac_data_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dac_data_q  <= dac_data_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign dac_l_valid_o = (state_q == ST_PUSH_L);
    assign dac_r_valid_o = (state_q == ST_PUSH_R);
    assign dac_l_data_o  = dac_data_q;
    assign dac_r_data_o  = dac_data_q;
    assign frame_cnt_o   = frame_cnt_q;

    audio_tape_slicer u_slicer (
        .clk         (clk_clk),
        .srst        (reset_reset),
        .sample_i    (adc_l_data_i),
        .strobe_i    (adc_l_fire),
        .thresh_hi_i (THRESH_HI),
        .thresh_lo_i (THRESH_LO),
        .level_o     (tape_in_o)
    );

endmodule
